// File: rtl/seg7_pattern_decoder_if.sv
// Interface for the seven-segment receive monitor.
// Carries the active-low segment lines and the decoded status outputs.
interface seg7_pattern_decoder_if #(
    parameter int unsigned ERR_W = 8
);
    logic             seg_a;
    logic             seg_b;
    logic             seg_c;
    logic             seg_d;
    logic             seg_e;
    logic             seg_f;
    logic             seg_g;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             bad_pattern;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
        input  digit, digit_valid, blank, bad_pattern, seq_err, locked, err_cnt
    );

    modport slave (
        input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
        output digit, digit_valid, blank, bad_pattern, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Seven-segment pattern decoder: glitch filter, BCD decode, error counting.
// Define SEG7_SEQ_CHECK_EN to enable the 0->9->0 sequence check.
//
// state    | meaning
// S_WAIT   | nothing accepted since reset
// S_SETTLE | candidate pattern counting toward STABLE_CYCLES
// S_HOLD   | candidate settled (accepted or equal to the accepted pattern)
module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_pattern_decoder_if.slave bus
);
    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [7:0] STAB_TC  = 8'(STABLE_CYCLES);
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    logic [1:0]       state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [6:0]       cand_q, cand_d;
    logic [6:0]       acc_q, acc_d;
    logic             acc_valid_q, acc_valid_d;
    logic [7:0]       stab_q, stab_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic             bad_q, bad_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             do_accept;
    logic             cand_legal;
    logic [3:0]       cand_val;
    logic             err_inc;

    // Returns {legal, value}; blank and illegal patterns report legal=0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'd0};
            7'b1001111: decode = {1'b1, 4'd1};
            7'b0010010: decode = {1'b1, 4'd2};
            7'b0000110: decode = {1'b1, 4'd3};
            7'b1001100: decode = {1'b1, 4'd4};
            7'b0100100: decode = {1'b1, 4'd5};
            7'b1100000: decode = {1'b1, 4'd6};
            7'b0001111: decode = {1'b1, 4'd7};
            7'b0000000: decode = {1'b1, 4'd8};
            7'b0001100: decode = {1'b1, 4'd9};
            default:    decode = {1'b0, 4'd0};
        endcase
    endfunction

    assign seg_d = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                    bus.seg_e, bus.seg_f, bus.seg_g};
    assign {cand_legal, cand_val} = decode(cand_q);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        stab_d      = stab_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        locked_d    = locked_q;
        do_accept   = 1'b0;
        if (seg_q != cand_q) begin
            cand_d  = seg_q;
            stab_d  = 8'd1;
            state_d = S_SETTLE;
        end else if (state_q == S_SETTLE) begin
            if (stab_q == STAB_TC) begin
                state_d = S_HOLD;
                if (!(acc_valid_q && (cand_q == acc_q))) begin
                    do_accept   = 1'b1;
                    acc_d       = cand_q;
                    acc_valid_d = 1'b1;
                    locked_d    = 1'b1;
                end
            end else begin
                stab_d = stab_q + 8'd1;
            end
        end
    end

    always_comb begin
        digit_d = digit_q;
        blank_d = blank_q;
        valid_d = 1'b0;
        bad_d   = 1'b0;
        if (do_accept) begin
            if (cand_legal) begin
                digit_d = cand_val;
                valid_d = 1'b1;
                blank_d = 1'b0;
            end else if (cand_q == SEG_OFF) begin
                blank_d = 1'b1;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    logic prev_ok_q, prev_ok_d;
    logic seq_q, seq_d;

    always_comb begin
        prev_ok_d = prev_ok_q;
        seq_d     = 1'b0;
        if (do_accept) begin
            if (cand_legal) begin
                // Expected successor of the previous digit, wrapping 9 -> 0.
                if (prev_ok_q && (cand_val != ((digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1)))
                    seq_d = 1'b1;
                prev_ok_d = 1'b1;
            end else begin
                prev_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_ok_q <= 1'b0;
            seq_q     <= 1'b0;
        end else begin
            prev_ok_q <= prev_ok_d;
            seq_q     <= seq_d;
        end
    end

    assign err_inc     = bad_d | seq_d;
    assign bus.seq_err = seq_q;
`else
    assign err_inc     = bad_d;
    assign bus.seq_err = 1'b0;
`endif

    assign err_d = (err_inc && (err_q != {ERR_W{1'b1}})) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_WAIT;
            seg_q       <= SEG_OFF;
            cand_q      <= SEG_OFF;
            acc_q       <= SEG_OFF;
            acc_valid_q <= 1'b0;
            stab_q      <= 8'd0;
            digit_q     <= 4'd0;
            valid_q     <= 1'b0;
            blank_q     <= 1'b0;
            bad_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            cand_q      <= cand_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            stab_q      <= stab_d;
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = blank_q;
    assign bus.bad_pattern = bad_q;
    assign bus.locked      = locked_q;
    assign bus.err_cnt     = err_q;
endmodule
